alu_muldiv_ctrl: RTL and testbench

//   EX-stage ALU control with an integrated multi-cycle MULT/DIV unit and HI/LO registers.

---
 rtl/mips_alu_pkg.sv | 55 +++++
 rtl/muldiv_divider.sv | 47 ++++
 rtl/alu_muldiv_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: ALU operation codes, MIPS opcode/funct constants and mul/div FSM states
package mips_alu_pkg;

    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_XOR = 5'd5;
    localparam logic [4:0] ALU_NOR = 5'd6;
    localparam logic [4:0] ALU_SLL = 5'd7;
    localparam logic [4:0] ALU_SRL = 5'd8;
    localparam logic [4:0] ALU_SLT = 5'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative restoring unsigned divider, one quotient bit per cycle.
// last is high during the cycle that produces the final quotient bit.
module muldiv_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              last
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
    logic [DATA_W:0]   shifted, diff;

    assign shifted   = {rem_q, quo_q[DATA_W-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign last      = cnt_q == CW'(1);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // A zero divisor never borrows, leaving all-ones quotient and the dividend as remainder
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            cnt_q <= CW'(DATA_W);
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            quo_q <= {quo_q[DATA_W-2:0], !diff[DATA_W]};
            rem_q <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: EX-stage ALU decode with an iterative mult/div unit and HI/LO registers.
// Define DIVZERO_TRAP_EN to add div_zero and trap divides by zero instead of running them.
module alu_muldiv_ctrl
    import mips_alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic [5:0]        op_code,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [4:0]        alu_ctrl,
    output logic              sign,
    output logic [DATA_W-1:0] hilo_rdata,
    output logic              busy,
    output logic              stall,
    output logic              done
`ifdef DIVZERO_TRAP_EN
    ,
    output logic              div_zero
`endif
);

    logic                rtype, is_mul, is_div, is_signed, muldiv;
    logic                is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic                issue, trap, rt_zero, div_last;
    logic [DATA_W-1:0]   mag_a, mag_b, quotient, remainder;
    logic [DATA_W-1:0]   hi_q, lo_q, a_q, b_q;
    logic                sa_q, sb_q, dz_q, done_q;
    logic [3:0]          cnt_q;
    logic [2*DATA_W-1:0] prod_u, prod;
    state_e              state_q;

    always_comb begin
        alu_ctrl = ALU_NOP;
        sign     = 1'b1;
        if (rtype) begin
            case (funct)
                FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
                FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
                FN_AND:          alu_ctrl = ALU_AND;
                FN_OR:           alu_ctrl = ALU_OR;
                FN_XOR:          alu_ctrl = ALU_XOR;
                FN_NOR:          alu_ctrl = ALU_NOR;
                FN_SLL:          alu_ctrl = ALU_SLL;
                FN_SRL, FN_SRA:  alu_ctrl = ALU_SRL;
                FN_SLT, FN_SLTU: alu_ctrl = ALU_SLT;
                default:         alu_ctrl = ALU_NOP;
            endcase
            sign = !(funct inside {FN_ADDU, FN_SUBU, FN_SLTU, FN_SLL, FN_SRL});
        end else begin
            case (op_code)
                OP_ADDI, OP_ADDIU, OP_LW, OP_LBU, OP_SW: alu_ctrl = ALU_ADD;
                OP_BEQ, OP_BNE:                          alu_ctrl = ALU_SUB;
                OP_SLTI, OP_SLTIU:                       alu_ctrl = ALU_SLT;
                default:                                 alu_ctrl = ALU_NOP;
            endcase
            sign = !(op_code inside {OP_ADDIU, OP_SLTIU});
        end
    end

    assign rtype     = op_code == OP_RTYPE;
    assign is_mul    = rtype && (funct == FN_MULT || funct == FN_MULTU);
    assign is_div    = rtype && (funct == FN_DIV || funct == FN_DIVU);
    assign is_mfhi   = rtype && funct == FN_MFHI;
    assign is_mflo   = rtype && funct == FN_MFLO;
    assign is_mthi   = rtype && funct == FN_MTHI;
    assign is_mtlo   = rtype && funct == FN_MTLO;
    assign is_signed = funct == FN_MULT || funct == FN_DIV;
    assign muldiv    = is_mul || is_div;

    assign busy       = state_q != ST_IDLE;
    assign stall      = valid && busy && (muldiv || is_mfhi || is_mflo || is_mthi || is_mtlo);
    assign issue      = valid && muldiv && !busy && !trap;
    assign rt_zero    = rt_val == '0;
    assign hilo_rdata = busy ? '0 : is_mfhi ? hi_q : is_mflo ? lo_q : '0;
    assign done       = done_q;

    // Both units work on magnitudes; signs are reapplied when HI/LO are written
    assign mag_a  = (is_signed && rs_val[DATA_W-1]) ? -rs_val : rs_val;
    assign mag_b  = (is_signed && rt_val[DATA_W-1]) ? -rt_val : rt_val;
    assign prod_u = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    assign prod   = (sa_q ^ sb_q) ? -prod_u : prod_u;

`ifdef DIVZERO_TRAP_EN
    logic dz_trap_q;
    assign trap     = valid && is_div && !busy && rt_zero;
    assign div_zero = dz_trap_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dz_trap_q <= 1'b0;
        else          dz_trap_q <= trap;
    end
`else
    assign trap = 1'b0;
`endif

    muldiv_divider #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (issue && is_div),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quotient),
        .remainder (remainder),
        .last      (div_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        a_q     <= mag_a;
                        b_q     <= mag_b;
                        sa_q    <= is_signed && rs_val[DATA_W-1];
                        sb_q    <= is_signed && rt_val[DATA_W-1];
                        dz_q    <= rt_zero;
                        cnt_q   <= 4'(MUL_LAT - 1);
                        state_q <= is_mul ? ST_MUL : ST_DIV;
                    end
                    if (valid && is_mthi) hi_q <= rs_val;
                    if (valid && is_mtlo) lo_q <= rs_val;
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_q, lo_q} <= prod;
                        done_q       <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DIV: begin
                    if (div_last) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    lo_q    <= ((sa_q ^ sb_q) && !dz_q) ? -quotient : quotient;
                    hi_q    <= sa_q ? -remainder : remainder;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: directed bench for alu_muldiv_ctrl with a HI/LO result scoreboard.
// Honours DIVZERO_TRAP_EN so it builds against either configuration.
module tb_alu_muldiv_ctrl;

    logic        clk = 1'b0, reset_n = 1'b1, valid = 1'b0;
    logic [5:0]  op_code = '0, funct = '0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic [4:0]  alu_ctrl;
    logic        sign, busy, stall, done;
    logic [31:0] hilo_rdata;
`ifdef DIVZERO_TRAP_EN
    logic        div_zero;
`endif

    int          tests = 0, fails = 0;
    logic [63:0] sb[$];

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] alu;
        logic       sg;
    } dec_t;
    dec_t tbl [36];

    alu_muldiv_ctrl #(.DATA_W(32), .MUL_LAT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (valid),
        .op_code    (op_code),
        .funct      (funct),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .alu_ctrl   (alu_ctrl),
        .sign       (sign),
        .hilo_rdata (hilo_rdata),
        .busy       (busy),
        .stall      (stall),
        .done       (done)
`ifdef DIVZERO_TRAP_EN
        ,
        .div_zero   (div_zero)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y, q, m;
        logic sgn;
        sgn = fn == 6'h18 || fn == 6'h1A;
        x = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        y = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        if (fn == 6'h18 || fn == 6'h19) return x * y;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = x / y;
        m = x % y;
        return {m[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        valid = 1'b1; op_code = 6'h00; funct = 6'h10;
        #1 check({tag, "_hi"}, hilo_rdata, hi);
        funct = 6'h12;
        #1 check({tag, "_lo"}, hilo_rdata, lo);
        valid = 1'b0; funct = 6'h00;
    endtask

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; op_code = 6'h00; funct = fn; rs_val = a; rt_val = b;
        sb.push_back(model(fn, a, b));
        tick();
        valid = 1'b0; funct = 6'h00;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic finish_op(input string tag, input int lat);
        int n;
        logic [63:0] e;
        wait_idle(n);
        check({tag, "_busy_cycles"}, n, lat);
        check({tag, "_done"}, done, 1);
        e = sb.pop_front();
        read_hilo(tag, e[63:32], e[31:0]);
        tick();
        check({tag, "_done_clear"}, done, 0);
    endtask

    initial begin
        int n, s, p;
        logic [63:0] e;
        tbl = '{
            '{6'h00, 6'h20, 5'd1, 1'b1}, '{6'h00, 6'h21, 5'd1, 1'b0}, '{6'h00, 6'h22, 5'd2, 1'b1},
            '{6'h00, 6'h23, 5'd2, 1'b0}, '{6'h00, 6'h24, 5'd3, 1'b1}, '{6'h00, 6'h25, 5'd4, 1'b1},
            '{6'h00, 6'h26, 5'd5, 1'b1}, '{6'h00, 6'h27, 5'd6, 1'b1}, '{6'h00, 6'h00, 5'd7, 1'b0},
            '{6'h00, 6'h02, 5'd8, 1'b0}, '{6'h00, 6'h03, 5'd8, 1'b1}, '{6'h00, 6'h2A, 5'd9, 1'b1},
            '{6'h00, 6'h2B, 5'd9, 1'b0}, '{6'h00, 6'h08, 5'd0, 1'b1}, '{6'h00, 6'h09, 5'd0, 1'b1},
            '{6'h00, 6'h18, 5'd0, 1'b1}, '{6'h00, 6'h19, 5'd0, 1'b1}, '{6'h00, 6'h1A, 5'd0, 1'b1},
            '{6'h00, 6'h1B, 5'd0, 1'b1}, '{6'h00, 6'h10, 5'd0, 1'b1}, '{6'h00, 6'h11, 5'd0, 1'b1},
            '{6'h00, 6'h12, 5'd0, 1'b1}, '{6'h00, 6'h13, 5'd0, 1'b1}, '{6'h00, 6'h3F, 5'd0, 1'b1},
            '{6'h08, 6'h00, 5'd1, 1'b1}, '{6'h09, 6'h00, 5'd1, 1'b0}, '{6'h23, 6'h00, 5'd1, 1'b1},
            '{6'h24, 6'h00, 5'd1, 1'b1}, '{6'h2B, 6'h00, 5'd1, 1'b1}, '{6'h04, 6'h00, 5'd2, 1'b1},
            '{6'h05, 6'h00, 5'd2, 1'b1}, '{6'h0A, 6'h00, 5'd9, 1'b1}, '{6'h0B, 6'h00, 5'd9, 1'b0},
            '{6'h0F, 6'h00, 5'd0, 1'b1}, '{6'h02, 6'h00, 5'd0, 1'b1}, '{6'h03, 6'h00, 5'd0, 1'b1}
        };

        #1 reset_n = 1'b0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        read_hilo("rst", 32'h0, 32'h0);
        reset_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            op_code = tbl[i].op;
            funct   = tbl[i].fn;
            #1 check($sformatf("decode_op%02h_fn%02h", tbl[i].op, tbl[i].fn),
                     {alu_ctrl, sign}, {tbl[i].alu, tbl[i].sg});
        end
        op_code = 6'h00; funct = 6'h00;
        tick();

        check("idle_busy", busy, 0);
        issue(6'h18, 32'hFFFF_FFFD, 32'd7);
        finish_op("mult_m3x7", 4);
        issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_m7d2", 33);
        issue(6'h1B, 32'd7, 32'd2);
        finish_op("divu_7d2", 33);
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 4);
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_min_m1", 33);

        valid = 1'b1; funct = 6'h11; rs_val = 32'h1234;
        tick();
        funct = 6'h13; rs_val = 32'h5678;
        tick();
        valid = 1'b0; funct = 6'h00;
        read_hilo("mthi_mtlo", 32'h1234, 32'h5678);

`ifdef DIVZERO_TRAP_EN
        valid = 1'b1; funct = 6'h1A; rs_val = 32'hFFFF_FFFB; rt_val = 32'd0;
        tick();
        valid = 1'b0; funct = 6'h00;
        check("dz_pulse", div_zero, 1);
        check("dz_busy", busy, 0);
        tick();
        check("dz_pulse_clear", div_zero, 0);
        check("dz_no_done", done, 0);
        read_hilo("dz_keep", 32'h1234, 32'h5678);
`else
        issue(6'h1A, 32'hFFFF_FFFB, 32'd0);
        finish_op("div_by_zero", 33);
`endif

        issue(6'h18, 32'd5, 32'd6);
        valid = 1'b1; op_code = 6'h00; funct = 6'h12;
        #1;
        n = 0; s = 0;
        while (busy === 1'b1 && n < 100) begin
            if (stall === 1'b1) s++;
            n++;
            tick();
        end
        check("mflo_stall_cycles", s, 4);
        check("mflo_busy_cycles", n, 4);
        check("mflo_stall_drop", stall, 0);
        e = sb.pop_front();
        check("mflo_after_busy", hilo_rdata, {32'h0, e[31:0]});
        read_hilo("mflo_mult", e[63:32], e[31:0]);
        tick();

        issue(6'h1B, 32'd100, 32'd7);
        repeat (9) tick();
        check("abort_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        read_hilo("abort", 32'h0, 32'h0);
        sb.delete();
        tick();
        reset_n = 1'b1;
        p = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) p++;
        end
        check("abort_no_done", p, 0);

        valid = 1'b1; op_code = 6'h00; funct = 6'h11; rs_val = 32'hAA;
        tick();
        valid = 1'b0; funct = 6'h00;
        read_hilo("post_abort_mthi", 32'hAA, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
